// File: rtl/balancer_pkg.sv
// -----------------------------------------------------------------------------
// balancer_pkg
// Shared types and helpers for the balancer poll scheduler.
//   INT / DATA_W : station data word is a 32-bit signed value (MSB index INT)
//   word_t       : one station data word
//   acc_t        : widest accumulator the scheduler can need (64 stations)
//   poll_state_e : scheduler FSM states
//   sat_add      : clamp a station value at zero and add it to a running sum
//   saturate     : reduce a running sum to the largest publishable R
// -----------------------------------------------------------------------------
package balancer_pkg;

    localparam int INT       = 31;
    localparam int DATA_W    = INT + 1;
    // Six extra bits hold the sum of up to 64 maximum-valued stations.
    localparam int ACC_MAX_W = DATA_W + 6;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic [ACC_MAX_W-1:0]     acc_t;

    typedef enum logic [1:0] {
        GAP,
        SELECT,
        REQ,
        PUBLISH
    } poll_state_e;

    // Largest value R may take: 2^INT - 1.
    localparam acc_t R_MAX = acc_t'((64'd1 << INT) - 64'd1);

    // Negative station readings count as empty. The headroom bits mean the
    // sum itself can never wrap, so saturation is applied only at publish.
    function automatic acc_t sat_add(input acc_t acc, input word_t s);
        acc_t addend;
        addend = s[DATA_W-1] ? '0 : acc_t'(s);
        return acc + addend;
    endfunction

    function automatic word_t saturate(input acc_t acc);
        if (acc > R_MAX) begin
            return word_t'(R_MAX);
        end
        return word_t'(acc);
    endfunction

endpackage

// File: rtl/balancer_accumulator.sv
// -----------------------------------------------------------------------------
// balancer_accumulator
// Per-sweep running sum and station count, plus the registered R/G values
// seen by every station. Driven by strobes from the scheduler FSM.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : start of sweep, zero the sum and count
//   add         : accumulate percentage (clamped at 0) and count the station
//   publish     : copy the saturated sum / count into total / count_out
//   percentage  : station S value, meaningful with add
//   total       : published R (reset 0)
//   count_out   : published G (reset 1, never 0)
// -----------------------------------------------------------------------------
module balancer_accumulator
    import balancer_pkg::*;
#(
    parameter int N_STATIONS = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  add,
    input  logic  publish,
    input  word_t percentage,
    output word_t total,
    output word_t count_out
);

    localparam int ACC_W = DATA_W + $clog2(N_STATIONS);
    localparam int CNT_W = $clog2(N_STATIONS + 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= ACC_W'(sat_add(acc_t'(acc), percentage));
            cnt <= cnt + CNT_W'(1);
        end
    end

    // G is forced to 1 for an empty sweep so downstream division is safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total     <= '0;
            count_out <= word_t'(1);
        end else if (publish) begin
            if (cnt == '0) begin
                total     <= '0;
                count_out <= word_t'(1);
            end else begin
                total     <= saturate(acc_t'(acc));
                count_out <= word_t'(cnt);
            end
        end
    end

endmodule

// File: rtl/balancer_poll_scheduler.sv
// -----------------------------------------------------------------------------
// balancer_poll_scheduler
// Round-robin poller sharing the station-status bus. Each sweep visits every
// slot, requests S from enabled stations, and publishes R (total, saturated)
// and G (station count) together in one cycle.
//
// Parameters: N_STATIONS (1..64), SWEEP_GAP (idle cycles between sweeps),
//             POLL_TIMEOUT (REQ cycles before a slot is skipped, macro only).
//             The data width INT is the package constant balancer_pkg::INT.
// Optional:   `define BALANCER_POLL_TIMEOUT_EN adds the REQ timeout and the
//             timeout_flags output; without it REQ waits for ack forever.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   station_enable[N]        per-slot enable, sampled when the slot is reached
//   poll_req / poll_idx      request to station poll_idx, held until ack
//   poll_ack                 station returns poll_percentage this cycle
//   poll_percentage          station S value
//   total_percentage_stored  published R
//   number_of_stations       published G
//   publish_valid            one-cycle pulse when R/G update
//   sweep_count              completed sweeps, wraps at 16 bits
//   timeout_flags[N]         (macro only) slots that timed out this sweep
// -----------------------------------------------------------------------------
module balancer_poll_scheduler
    import balancer_pkg::*;
#(
    parameter int N_STATIONS   = 8,
    parameter int SWEEP_GAP    = 60,
    parameter int POLL_TIMEOUT = 16,
    localparam int IDX_W       = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_STATIONS-1:0]    station_enable,
    output logic                     poll_req,
    output logic [IDX_W-1:0]         poll_idx,
    input  logic                     poll_ack,
    input  logic signed [DATA_W-1:0] poll_percentage,
    output logic [DATA_W-1:0]        total_percentage_stored,
    output logic [DATA_W-1:0]        number_of_stations,
    output logic                     publish_valid,
    output logic [15:0]              sweep_count
`ifdef BALANCER_POLL_TIMEOUT_EN
    ,
    output logic [N_STATIONS-1:0]    timeout_flags
`endif
);

    localparam int GAP_W = (SWEEP_GAP > 0) ? $clog2(SWEEP_GAP + 1) : 1;

    if (N_STATIONS < 1 || N_STATIONS > 64 || SWEEP_GAP < 0 || POLL_TIMEOUT < 1) begin : g_bad_params
        $error("balancer_poll_scheduler: parameter out of range");
    end

    poll_state_e      state;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] idx;

    logic gap_done;
    logic last_slot;
    logic timed_out;
    logic slot_done;
    logic clear_acc;
    logic add_acc;
    logic publish_acc;

`ifdef BALANCER_POLL_TIMEOUT_EN
    localparam int TO_W = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt;
`endif

    assign poll_idx = idx;

    always_comb begin
        // NOTE: each combinational signal is assigned a default first so no
        // path through the block can infer a latch.
        gap_done    = (int'(gap_cnt) + 1 >= SWEEP_GAP);
        last_slot   = (idx == IDX_W'(N_STATIONS - 1));
        timed_out   = 1'b0;
`ifdef BALANCER_POLL_TIMEOUT_EN
        timed_out   = (state == REQ) && !poll_ack && (to_cnt == TO_W'(POLL_TIMEOUT - 1));
`endif
        clear_acc   = (state == GAP) && gap_done;
        add_acc     = (state == REQ) && poll_ack;
        publish_acc = (state == PUBLISH);
        // A slot finishes when skipped in SELECT, or when its REQ ends.
        slot_done   = ((state == SELECT) && !station_enable[idx]) ||
                      ((state == REQ) && (poll_ack || timed_out));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= GAP;
            gap_cnt       <= '0;
            idx           <= '0;
            poll_req      <= 1'b0;
            publish_valid <= 1'b0;
            sweep_count   <= '0;
`ifdef BALANCER_POLL_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_flags <= '0;
`endif
        end else begin
            publish_valid <= 1'b0;
            case (state)
                GAP: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                        idx     <= '0;
                        state   <= SELECT;
`ifdef BALANCER_POLL_TIMEOUT_EN
                        timeout_flags <= '0;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                SELECT: begin
                    // The enable is looked at only here; a slot already in
                    // REQ is completed even if its enable drops.
                    if (station_enable[idx]) begin
                        poll_req <= 1'b1;
                        state    <= REQ;
`ifdef BALANCER_POLL_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (poll_ack || timed_out) begin
                        poll_req <= 1'b0;
                    end
`ifdef BALANCER_POLL_TIMEOUT_EN
                    if (timed_out) begin
                        timeout_flags[idx] <= 1'b1;
                    end else if (!poll_ack) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                PUBLISH: begin
                    publish_valid <= 1'b1;
                    sweep_count   <= sweep_count + 16'd1;
                    state         <= GAP;
                end
                default: state <= GAP;
            endcase

            if (slot_done) begin
                if (last_slot) begin
                    state <= PUBLISH;
                end else begin
                    idx   <= idx + IDX_W'(1);
                    state <= SELECT;
                end
            end
        end
    end

    balancer_accumulator #(
        .N_STATIONS (N_STATIONS)
    ) u_accumulator (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_acc),
        .add        (add_acc),
        .publish    (publish_acc),
        .percentage (poll_percentage),
        .total      (total_percentage_stored),
        .count_out  (number_of_stations)
    );

endmodule
